// File: rtl/cart_led_if.sv
// ---------------------------------------------------------------------------
// cart_led_if -- bundle of the per-channel LED control signals.
//
// Signals (widths follow CHANNELS):
//   i_trigger    [CHANNELS-1:0]   per-channel activity pulse, bit c = channel c
//   i_mode       [2*CHANNELS-1:0] per-channel mode, bits [2c+1:2c]
//                                 0 OFF, 1 ON, 2 ACTIVITY, 3 BLINK
//   i_brightness [7:0]            global PWM duty shared by all channels
//   o_led        [CHANNELS-1:0]   registered LED drive, active-high
//
// Handshake: there is no valid/ready pair. Inputs are level-sampled on every
// rising clock edge. o_led is a plain registered output that is valid on
// every cycle once reset is released.
//
// Modports:
//   master -- drives trigger/mode/brightness, observes o_led
//   slave  -- the controller: consumes the inputs and drives o_led
// ---------------------------------------------------------------------------
interface cart_led_if #(
  parameter int CHANNELS = 3
);
  logic [CHANNELS-1:0]   i_trigger;
  logic [2*CHANNELS-1:0] i_mode;
  logic [7:0]            i_brightness;
  logic [CHANNELS-1:0]   o_led;

  modport master (
    output i_trigger,
    output i_mode,
    output i_brightness,
    input  o_led
  );

  modport slave (
    input  i_trigger,
    input  i_mode,
    input  i_brightness,
    output o_led
  );
endinterface

// File: rtl/cart_led_ctrl.sv
// ---------------------------------------------------------------------------
// cart_led_ctrl -- multi-channel LED controller.
//
// Each channel displays one of four modes: OFF, ON, ACTIVITY (a trigger is
// stretched to HOLD_CYCLES clocks), or BLINK (a shared phase that toggles
// every PRESCALE*BLINK_TICKS clocks). The selected level is gated by a global
// 8-bit PWM duty and then registered onto o_led.
//
// Ports:
//   i_clk      single clock, rising edge
//   i_reset_n  asynchronous active-low reset; clears every counter and o_led
//   bus        cart_led_if.slave (i_trigger, i_mode, i_brightness, o_led)
//
// Parameters:
//   CHANNELS     1..8      number of independent channels
//   HOLD_CYCLES  1..65535  activity stretch length in clocks
//   PRESCALE     2..65536  clocks per blink tick
//   BLINK_TICKS  1..65535  ticks per blink half-period
// ---------------------------------------------------------------------------
module cart_led_ctrl #(
  parameter int CHANNELS    = 3,
  parameter int HOLD_CYCLES = 31,
  parameter int PRESCALE    = 1000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  cart_led_if.slave  bus
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int PW = $clog2(PRESCALE);
  // A single-tick half-period still needs a 1-bit counter to stay legal.
  localparam int TW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(BLINK_TICKS - 1);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_ACT   = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  logic [HW-1:0]       r_hold [CHANNELS];
  logic [PW-1:0]       r_presc;
  logic [TW-1:0]       r_tick_cnt;
  logic                r_phase;
  logic [7:0]          r_pwm_cnt;
  logic [CHANNELS-1:0] r_led;

  logic                w_tick;
  logic                w_pwm_on;
  logic [CHANNELS-1:0] w_raw;

  // Hold counters run in every mode, so switching a channel into ACTIVITY
  // shows whatever stretch is still pending. A trigger always reloads, which
  // makes a retrigger restart the stretch.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int c = 0; c < CHANNELS; c++) r_hold[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.i_trigger[c]) begin
          r_hold[c] <= HOLD_LOAD;
        end else if (r_hold[c] != '0) begin
          r_hold[c] <= r_hold[c] - HW'(1);
        end
      end
    end
  end

  // The tick is asserted during the last prescaler count, so the state it
  // advances updates on the same edge that wraps the prescaler.
  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
      r_phase    <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        if (r_tick_cnt == TICK_LAST) begin
          r_tick_cnt <= '0;
          r_phase    <= ~r_phase;
        end else begin
          r_tick_cnt <= r_tick_cnt + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_pwm_cnt <= '0;
    else            r_pwm_cnt <= r_pwm_cnt + 8'd1;
  end

  // Full scale is special-cased so that 255 really means always on rather
  // than 255 of 256 cycles.
  assign w_pwm_on = (bus.i_brightness == 8'hFF) || (r_pwm_cnt < bus.i_brightness);

  always_comb begin
    w_raw = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (bus.i_mode[2*c +: 2])
        MODE_OFF:   w_raw[c] = 1'b0;
        MODE_ON:    w_raw[c] = 1'b1;
        MODE_ACT:   w_raw[c] = (r_hold[c] != '0);
        MODE_BLINK: w_raw[c] = r_phase;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_led <= '0;
    else            r_led <= w_raw & {CHANNELS{w_pwm_on}};
  end

  assign bus.o_led = r_led;

endmodule
